// File: rtl/fft_stage_sched.sv
`default_nettype none
// ============================================================================
// Module      : fft_stage_sched
// Description : Issue scheduler for an in-place radix-2 DIT FFT. Generates
//               butterfly read/twiddle addresses, multiplier and write-back
//               strobes, and drains the pipeline between stages.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_sched #(
    parameter int LOG2N  = 10,
    parameter int RD_LAT = 1,
    parameter int WB_LAT = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     hold_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(LOG2N)-1:0] stage_o,
    output logic                     rd_en_o,
    output logic [LOG2N-1:0]         rd_addr_a_o,
    output logic [LOG2N-1:0]         rd_addr_b_o,
    output logic [LOG2N-2:0]         tw_addr_o,
    output logic                     mult_valid_o,
    output logic                     wb_en_o,
    output logic [LOG2N-1:0]         wb_addr_a_o,
    output logic [LOG2N-1:0]         wb_addr_b_o
);

    localparam int SW = $clog2(LOG2N);
    localparam int KW = LOG2N - 1;
    localparam int CW = $clog2(WB_LAT + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    localparam logic [KW-1:0]    c_k_last = '1;
    localparam logic [KW-1:0]    c_k_one  = KW'(1);
    localparam logic [SW-1:0]    c_s_last = SW'(LOG2N - 1);
    localparam logic [SW-1:0]    c_s_one  = SW'(1);
    localparam logic [CW-1:0]    c_c_one  = CW'(1);
    localparam logic [LOG2N-1:0] c_n_one  = LOG2N'(1);

    logic [1:0]       r_state;
    logic [SW-1:0]    r_s;
    logic [KW-1:0]    r_k;
    logic             r_busy;
    logic             r_done;
    logic             r_rd_en;
    logic [LOG2N-1:0] r_addr_a;
    logic [LOG2N-1:0] r_addr_b;
    logic [KW-1:0]    r_tw;
    logic [CW-1:0]    r_inflight;
    logic [WB_LAT-1:0] r_vld;
    logic [LOG2N-1:0] r_dly_a [WB_LAT];
    logic [LOG2N-1:0] r_dly_b [WB_LAT];

    logic [1:0]       w_nxt_state;
    logic             w_issue;
    logic             w_done;
    logic [SW-1:0]    w_iss_s;
    logic [KW-1:0]    w_iss_k;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_drained;
    logic [LOG2N-1:0] w_span;
    logic [LOG2N-1:0] w_pos;
    logic [LOG2N-1:0] w_grp;
    logic [LOG2N-1:0] w_a;
    logic [LOG2N-1:0] w_b;
    logic [KW-1:0]    w_tw;

    // Stage exit looks at next-cycle occupancy so the new stage issues in the
    // cycle right after the final write-back of the previous one.
    always_comb begin
        w_cnt_nxt = r_inflight;
        if (r_rd_en && !r_vld[WB_LAT-1]) begin
            w_cnt_nxt = r_inflight + c_c_one;
        end else if (!r_rd_en && r_vld[WB_LAT-1]) begin
            w_cnt_nxt = r_inflight - c_c_one;
        end
    end

    assign w_drained = (w_cnt_nxt == '0);

    always_comb begin
        w_nxt_state = r_state;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        w_iss_s     = r_s;
        w_iss_k     = r_k;
        case (r_state)
            c_st_idle: begin
                if (start_i && !r_done) begin
                    w_issue     = 1'b1;
                    w_iss_s     = '0;
                    w_iss_k     = '0;
                    w_nxt_state = c_st_issue;
                end
            end
            c_st_issue: begin
                if (r_k == c_k_last) begin
                    w_nxt_state = c_st_drain;
                end else if (!hold_i) begin
                    w_issue = 1'b1;
                    w_iss_k = r_k + c_k_one;
                end
            end
            c_st_drain: begin
                if (w_drained) begin
                    if (r_s == c_s_last) begin
                        w_done      = 1'b1;
                        w_nxt_state = c_st_idle;
                    end else begin
                        w_issue     = 1'b1;
                        w_iss_s     = r_s + c_s_one;
                        w_iss_k     = '0;
                        w_nxt_state = c_st_issue;
                    end
                end
            end
            default: w_nxt_state = c_st_idle;
        endcase
    end

    // Butterfly k of stage s: group index picks the block, position within
    // the block picks the leg offset and scales the twiddle index.
    assign w_span = c_n_one << w_iss_s;
    assign w_pos  = {1'b0, w_iss_k} & (w_span - c_n_one);
    assign w_grp  = {1'b0, w_iss_k} >> w_iss_s;
    assign w_a    = ((w_grp << 1) << w_iss_s) | w_pos;
    assign w_b    = w_a + w_span;
    assign w_tw   = w_pos[KW-1:0] << (c_s_last - w_iss_s);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= c_st_idle;
            r_s        <= '0;
            r_k        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_tw       <= '0;
            r_inflight <= '0;
            r_vld      <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                r_dly_a[i] <= '0;
                r_dly_b[i] <= '0;
            end
        end else begin
            r_state    <= w_nxt_state;
            r_busy     <= (w_nxt_state != c_st_idle);
            r_done     <= w_done;
            r_rd_en    <= w_issue;
            r_inflight <= w_cnt_nxt;
            if (w_issue) begin
                r_s      <= w_iss_s;
                r_k      <= w_iss_k;
                r_addr_a <= w_a;
                r_addr_b <= w_b;
                r_tw     <= w_tw;
            end
            r_vld      <= {r_vld[WB_LAT-2:0], r_rd_en};
            r_dly_a[0] <= r_addr_a;
            r_dly_b[0] <= r_addr_b;
            for (int i = 1; i < WB_LAT; i++) begin
                r_dly_a[i] <= r_dly_a[i-1];
                r_dly_b[i] <= r_dly_b[i-1];
            end
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign stage_o      = r_s;
    assign rd_en_o      = r_rd_en;
    assign rd_addr_a_o  = r_addr_a;
    assign rd_addr_b_o  = r_addr_b;
    assign tw_addr_o    = r_tw;
    assign mult_valid_o = r_vld[RD_LAT-1];
    assign wb_en_o      = r_vld[WB_LAT-1];
    assign wb_addr_a_o  = r_dly_a[WB_LAT-1];
    assign wb_addr_b_o  = r_dly_b[WB_LAT-1];

endmodule
`default_nettype wire
